// File: rtl/seq_div32_pkg.sv
// Shared types and constants for the iterative 32-bit restoring divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;

  localparam logic [DIV_W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  // Two's-complement magnitude of v when it is a negative signed operand.
  function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v, input logic is_signed);
    div_mag = (is_signed && v[DIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/seq_div32_if.sv
// Request/result bundle for seq_div32; the sign line exists only with DIV_SIGNED_EN.
interface seq_div32_if;
  import div_pkg::*;

  // Handshake: start is taken whenever the divider is idle or in its done cycle;
  // busy covers the operation through done, done pulses for one cycle, and
  // quotient/remainder/dz hold from done until the next completed operation.
  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             sign;
`endif
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             dz;

  modport master (
    output start, dividend, divisor,
`ifdef DIV_SIGNED_EN
    output sign,
`endif
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef DIV_SIGNED_EN
    input  sign,
`endif
    output busy, done, quotient, remainder, dz
  );

endinterface

// File: rtl/seq_div32_step.sv
// One restoring-division step: shift one dividend bit in, trial-subtract, keep on no borrow.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic             q_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] next_rem,
  output logic             q_bit
);

  logic [DIV_W-1:0] rem_sh;
  logic [DIV_W:0]   trial;

  always_comb begin
    rem_sh = {rem[DIV_W-2:0], q_msb};
    trial  = {1'b0, rem_sh} - {1'b0, divisor};
    // A set rem MSB means the shifted partial remainder is >= 2^32 > divisor,
    // so the subtraction always succeeds and trial[31:0] is still exact.
    q_bit    = rem[DIV_W-1] | ~trial[DIV_W];
    next_rem = q_bit ? trial[DIV_W-1:0] : rem_sh;
  end

endmodule

// File: rtl/seq_div32.sv
// Iterative 32-bit restoring divider, one quotient bit per clock.
// Signed operation (sign input, magnitude capture, result fix-up) is built only with DIV_SIGNED_EN.
module seq_div32
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  seq_div32_if.slave  bus,
  output div_state_t  dbg_state
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] quot_q, quot_d;
  logic [DIV_W-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic             accept;
  logic             in_sign;
  logic [DIV_W-1:0] step_rem;
  logic             step_q_bit;
  logic [DIV_W-1:0] q_next;

  div_step u_step (
    .rem      (rem_q),
    .q_msb    (q_q[DIV_W-1]),
    .divisor  (div_q),
    .next_rem (step_rem),
    .q_bit    (step_q_bit)
  );

`ifdef DIV_SIGNED_EN
  assign in_sign = bus.sign;
`else
  assign in_sign = 1'b0;
`endif

  assign q_next = {q_q[DIV_W-2:0], step_q_bit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    div_d   = div_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    accept  = 1'b0;

    case (state_q)
      IDLE: accept = bus.start;
      RUN: begin
        rem_d = step_rem;
        q_d   = q_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIN;
          dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
          quot_d  = neg_quo_q ? -q_next : q_next;
          remo_d  = neg_rem_q ? -step_rem : step_rem;
`else
          quot_d  = q_next;
          remo_d  = step_rem;
`endif
        end
      end
      // The done cycle also takes a new request so back-to-back starts lose no cycle.
      FIN: begin
        state_d = IDLE;
        accept  = bus.start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d = '0;
      rem_d = '0;
      q_d   = div_mag(bus.dividend, in_sign);
      div_d = div_mag(bus.divisor, in_sign);
`ifdef DIV_SIGNED_EN
      neg_quo_d = in_sign & (bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1]);
      neg_rem_d = in_sign & bus.dividend[DIV_W-1];
`endif
      if (bus.divisor == '0) begin
        state_d = FIN;
        quot_d  = DZ_QUOT;
        remo_d  = bus.dividend;
        dz_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;
  assign bus.dz        = dz_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_div32.sv
// Directed bench for seq_div32: latency, results, divide-by-zero, held start, async reset.
module tb_seq_div32;
  import div_pkg::*;

  logic       clk;
  logic       rst;
  div_state_t dbg_state;
  int         vectors;
  int         fails;
  int         cyc;

  seq_div32_if bus ();

  seq_div32 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sign(input logic s);
`ifdef DIV_SIGNED_EN
    bus.sign = s;
`else
    if (s) $display("note: sign request ignored in unsigned build");
`endif
  endtask

  // Drive a request before an edge; returns in cycle 1 with start dropped.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    set_sign(s);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  // Counts cycles from cycle 1 until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int exp_cyc, input logic [31:0] eq, input logic [31:0] er, input logic edz);
    start_op(a, b, s);
    wait_done(cyc);
    check({tag, ".lat"}, 32'(cyc), 32'(exp_cyc));
    check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, ".q"}, bus.quotient, eq);
    check({tag, ".r"}, bus.remainder, er);
    check({tag, ".dz"}, {31'd0, bus.dz}, {31'd0, edz});
    @(posedge clk);
    #1;
    check({tag, ".idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, ".hold"}, bus.quotient, eq);
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    set_sign(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check("rst.q", bus.quotient, 32'd0);
    check("rst.r", bus.remainder, 32'd0);
    check("rst.dz", {31'd0, bus.dz}, 32'd0);
    check("rst.state", {30'd0, dbg_state}, {30'd0, IDLE});

    run_op("d100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    run_op("max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("d5_9", 32'd5, 32'd9, 1'b0, 33, 32'd0, 32'd5, 1'b0);
    run_op("big_div", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 33, 32'd1, 32'h7FFF_FFFE, 1'b0);
    run_op("dz", 32'd1234, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    run_op("dz_clr", 32'd50, 32'd5, 1'b0, 33, 32'd10, 32'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0);
    run_op("s_dz", 32'hFFFF_FFF9, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    set_sign(1'b0);
`endif

    // Start held high: operands churn while busy, next op taken in the done cycle.
    @(negedge clk);
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      bus.dividend = $urandom;
      bus.divisor  = 32'($urandom_range(1, 1000));
      @(posedge clk);
      #1;
      cyc++;
    end
    check("hold.lat", 32'(cyc), 32'd33);
    check("hold.q", bus.quotient, 32'd14);
    check("hold.r", bus.remainder, 32'd2);
    bus.dividend = 32'd200;
    bus.divisor  = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b.busy", {30'd0, bus.busy, bus.done}, 32'd2);
    check("b2b.held", bus.quotient, 32'd14);
    wait_done(cyc);
    check("b2b.lat", 32'(cyc), 32'd33);
    check("b2b.q", bus.quotient, 32'd22);
    check("b2b.r", bus.remainder, 32'd2);

    // Asynchronous reset in cycle 10 of an operation.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("arst.busy", {31'd0, bus.busy}, 32'd0);
    check("arst.done", {31'd0, bus.done}, 32'd0);
    check("arst.q", bus.quotient, 32'd0);
    check("arst.r", bus.remainder, 32'd0);
    check("arst.dz", {31'd0, bus.dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
